// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_t;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory between instruction fetch and data access,
// sequencing a fixed-latency access and returning read data with a done pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned size = 16,
    parameter int unsigned LAT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [size-1:0] if_addr,
    output logic            if_done,
    output logic [size-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [size-1:0] dm_addr,
    input  logic [size-1:0] dm_wdata,
    output logic            dm_done,
    output logic [size-1:0] dm_rdata,
    output logic            sel,
    output logic            mem_en,
    output logic            mem_we,
    output logic [size-1:0] mem_addr,
    output logic [size-1:0] mem_wdata,
    input  logic [size-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(LAT) + 1;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             w_grant;
    logic             w_start;
    logic             w_finish;
    logic             w_retire;
    logic             w_last_beat;
    logic [size-1:0]  w_mux_addr;
    logic [size-1:0]  w_mux_wdata;
    logic             w_mux_we;

    // On a conflict the requester not served last wins.
    always_comb begin
        w_grant = SEL_FETCH;
        if (if_req && dm_req) begin
            w_grant = (r_last == SEL_DATA) ? SEL_FETCH : SEL_DATA;
        end else if (dm_req) begin
            w_grant = SEL_DATA;
        end
    end

    // 2:1 mux ahead of the address/write-data latches
    assign w_mux_addr  = (w_grant == SEL_DATA) ? dm_addr  : if_addr;
    assign w_mux_wdata = (w_grant == SEL_DATA) ? dm_wdata : '0;
    assign w_mux_we    = (w_grant == SEL_DATA) && dm_we;
    assign w_last_beat = (r_cnt == CNT_W'(LAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_start     = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_RESP;
                    w_finish    = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_retire    = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant latches, access counter, read capture and done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_last    <= SEL_DATA;
            sel       <= SEL_FETCH;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            if (w_start) begin
                sel       <= w_grant;
                mem_addr  <= w_mux_addr;
                mem_wdata <= w_mux_wdata;
                mem_we    <= w_mux_we;
                mem_en    <= 1'b1;
                r_cnt     <= '0;
            end
            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                mem_en  <= 1'b0;
                mem_we  <= 1'b0;
                if_done <= (sel == SEL_FETCH);
                dm_done <= (sel == SEL_DATA);
                if (!mem_we) begin
                    if (sel == SEL_DATA) begin
                        dm_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
            end
            if (w_retire) begin
                if_done <= 1'b0;
                dm_done <= 1'b0;
                r_last  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level schedule model.
module tb_mem_port_arbiter;

    localparam int unsigned W   = 16;
    localparam int          LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req;
    logic [W-1:0] if_addr;
    logic         if_done;
    logic [W-1:0] if_rdata;
    logic         dm_req;
    logic         dm_we;
    logic [W-1:0] dm_addr;
    logic [W-1:0] dm_wdata;
    logic         dm_done;
    logic [W-1:0] dm_rdata;
    logic         sel;
    logic         mem_en;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    mem_port_arbiter #(.size(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .sel       (sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction schedule model: a grant at edge g drives the memory for LAT
    // cycles, done in the cycle after edge g+LAT, next grant possible at g+LAT+2.
    int           edge_n = 0;
    bit           m_busy;
    int           m_start;
    bit           m_owner;
    bit           m_last;
    bit           m_we;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    bit           exp_sel;
    logic [W-1:0] exp_mem_addr;
    logic [W-1:0] exp_if_rdata;
    logic [W-1:0] exp_dm_rdata;
    logic [W-1:0] drv_rdata;
    bit           use_ovr = 1'b0;
    logic [W-1:0] ovr_val = '0;
    bit           if_act = 1'b0;
    bit           dm_act = 1'b0;

    function automatic logic [W-1:0] mem_model(input logic [W-1:0] a);
        if (use_ovr) return ovr_val;
        return W'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic int phase();
        return m_busy ? (edge_n - m_start) : -1;
    endfunction

    task automatic model_reset();
        m_busy       = 1'b0;
        m_start      = 0;
        m_owner      = 1'b0;
        m_last       = 1'b1;
        m_we         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        exp_sel      = 1'b0;
        exp_mem_addr = '0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endtask

    task automatic step();
        bit s_if, s_dm;
        int k;
        bit en;
        @(posedge clk);
        edge_n++;
        s_if = if_req;
        s_dm = dm_req;
        if (rst) begin
            model_reset();
        end else begin
            if (m_busy && (edge_n - m_start) == LAT && !m_we) begin
                if (m_owner) exp_dm_rdata = drv_rdata;
                else         exp_if_rdata = drv_rdata;
            end
            if (m_busy && (edge_n - m_start) >= LAT + 2) m_busy = 1'b0;
            if (!m_busy && (s_if || s_dm)) begin
                m_owner      = (s_if && s_dm) ? !m_last : s_dm;
                m_last       = m_owner;
                m_busy       = 1'b1;
                m_start      = edge_n;
                m_addr       = m_owner ? dm_addr : if_addr;
                m_we         = m_owner ? dm_we : 1'b0;
                m_wdata      = dm_wdata;
                exp_sel      = m_owner;
                exp_mem_addr = m_addr;
            end
        end
        #1;
        k  = phase();
        en = m_busy && k >= 0 && k < LAT;
        check_eq("mem_en",   W'(mem_en),  W'(en));
        check_eq("mem_we",   W'(mem_we),  W'(en && m_we));
        check_eq("sel",      W'(sel),     W'(exp_sel));
        check_eq("if_done",  W'(if_done), W'(m_busy && k == LAT && !m_owner));
        check_eq("dm_done",  W'(dm_done), W'(m_busy && k == LAT && m_owner));
        check_eq("mem_addr", mem_addr,    exp_mem_addr);
        check_eq("if_rdata", if_rdata,    exp_if_rdata);
        check_eq("dm_rdata", dm_rdata,    exp_dm_rdata);
        if (en && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        mem_rdata = (en && k == LAT - 1 && !m_we) ? mem_model(m_addr) : W'($urandom);
        drv_rdata = mem_rdata;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (m_busy && phase() == LAT) begin
                if (m_owner) dm_req = 1'b0;
                else         if_req = 1'b0;
            end
        end
    endtask

    // Requesters obey the hold-until-done rule; after a grant they may drop
    // req or scramble address/data, which the latches must ignore.
    task automatic drive_random();
        int k;
        k = phase();
        if (if_act) begin
            if (m_busy && !m_owner && k == LAT) begin
                if_req = 1'b0;
                if_act = 1'b0;
            end else if (m_busy && !m_owner) begin
                if ($urandom_range(7) == 0) if_req = 1'b0;
                if_addr = W'($urandom);
            end
        end else if ($urandom_range(2) == 0) begin
            if_req  = 1'b1;
            if_addr = W'($urandom);
            if_act  = 1'b1;
        end
        if (dm_act) begin
            if (m_busy && m_owner && k == LAT) begin
                dm_req = 1'b0;
                dm_act = 1'b0;
            end else if (m_busy && m_owner) begin
                if ($urandom_range(7) == 0) dm_req = 1'b0;
                dm_addr  = W'($urandom);
                dm_wdata = W'($urandom);
                dm_we    = 1'($urandom_range(1));
            end
        end else if ($urandom_range(2) == 0) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(1));
            dm_addr  = W'($urandom);
            dm_wdata = W'($urandom);
            dm_act   = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int if_edge, dm_edge;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        drv_rdata = '0;
        model_reset();
        do_reset();

        // fetch read returning 0xBEEF
        use_ovr = 1'b1;
        ovr_val = 16'hBEEF;
        if_req  = 1'b1;
        if_addr = 16'h0010;
        run_cycles(6);
        check_eq("s1_if_rdata", if_rdata, 16'hBEEF);
        use_ovr = 1'b0;

        // data write leaves dm_rdata untouched
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0200;
        dm_wdata = 16'h1234;
        run_cycles(6);
        check_eq("s2_dm_rdata", dm_rdata, 16'h0000);

        // conflict right after reset: fetch first, then alternate
        do_reset();
        if_req  = 1'b1;
        if_addr = 16'h0030;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 16'h0300;
        if_edge = -1;
        dm_edge = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (if_done && if_edge < 0) if_edge = edge_n;
            if (dm_done && dm_edge < 0) dm_edge = edge_n;
        end
        check_eq("s3_fetch_first", W'(if_edge >= 0 && dm_edge > if_edge), W'(1));
        check_eq("s3_gap", W'(dm_edge - if_edge), W'(4));
        if_req = 1'b0;
        dm_req = 1'b0;
        run_cycles(6);

        // request dropped and address scrambled mid-access
        if_req  = 1'b1;
        if_addr = 16'h0040;
        step();
        step();
        if_req  = 1'b0;
        if_addr = 16'hFFFF;
        run_cycles(5);
        check_eq("s4_if_rdata", if_rdata, mem_model(16'h0040));

        // asynchronous reset in the second access cycle
        if_req  = 1'b1;
        if_addr = 16'h0080;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("s5_mem_en",   W'(mem_en),  W'(0));
        check_eq("s5_if_done",  W'(if_done), W'(0));
        check_eq("s5_mem_addr", mem_addr,    16'h0000);
        check_eq("s5_if_rdata", if_rdata,    16'h0000);
        model_reset();
        if_req = 1'b0;
        step();
        @(negedge clk);
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0090;
        run_cycles(6);
        check_eq("s5_after", if_rdata, mem_model(16'h0090));

        // randomized traffic
        if_act = 1'b0;
        dm_act = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            drive_random();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        run_cycles(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
